// File: rtl/debug_unit.sv
// Byte-command sequencer sitting between a UART byte link and the accumulator CPU:
// loads program memory, gates the CPU clock-enable and reports PC/ACC/cycle count.
module debug_unit #(
  parameter int BITS     = 16,
  parameter int ADDR     = BITS - 5,
  parameter int CNT_BITS = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [7:0]      i_rx_data,
  input  logic            i_rx_valid,
  output logic [7:0]      o_tx_data,
  output logic            o_tx_start,
  input  logic            i_tx_done,
  output logic            o_cpu_en,
  output logic            o_cpu_rst,
  output logic            o_imem_we,
  output logic [ADDR-1:0] o_imem_addr,
  output logic [BITS-1:0] o_imem_data,
  input  logic [ADDR-1:0] i_pc,
  input  logic [BITS-1:0] i_acc,
  input  logic            i_halt
);

  localparam int OP_W   = BITS - ADDR;
  localparam int REP_W  = 2 * BITS + CNT_BITS;
  localparam int NBYTES = REP_W / 8;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam logic [ADDR-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {IDLE, LD_HI, LD_LO, LD_WR, RUN, STEP, TX, TX_WAIT} state_t;

  state_t                state;
  logic [ADDR-1:0]       ld_addr;
  logic [BITS-9:0]       hi_byte;
  logic [CNT_BITS-1:0]   cnt;
  logic [IDX_W-1:0]      byte_idx;
  logic [REP_W-1:0]      snap;
  logic [REP_W-1:0]      report_now;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (c == '1) ? c : c + CNT_BITS'(1);
  endfunction

  // A load ends on the HLT word or on the top address; the address never wraps.
  function automatic logic is_last(input logic [BITS-1:0] w, input logic [ADDR-1:0] a);
    return (w[BITS-1 -: OP_W] == '0) || (a == ADDR_MAX);
  endfunction

  function automatic logic [7:0] byte_of(input logic [REP_W-1:0] rep,
                                         input logic [IDX_W-1:0] idx);
    logic [REP_W-1:0] sh;
    sh = rep >> (8 * (NBYTES - 1 - int'(idx)));
    return sh[7:0];
  endfunction

  assign report_now = {{(BITS-ADDR){1'b0}}, i_pc, i_acc, cnt};

  // Combinational so the CPU stops on the very cycle its halt is visible.
  assign o_cpu_en = ((state == RUN) || (state == STEP)) && !i_halt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      ld_addr     <= '0;
      hi_byte     <= '0;
      cnt         <= '0;
      byte_idx    <= '0;
      snap        <= '0;
      o_tx_data   <= '0;
      o_tx_start  <= 1'b0;
      o_cpu_rst   <= 1'b0;
      o_imem_we   <= 1'b0;
      o_imem_addr <= '0;
      o_imem_data <= '0;
    end else begin
      o_tx_start <= 1'b0;
      o_cpu_rst  <= 1'b0;
      o_imem_we  <= 1'b0;
      case (state)
        IDLE: if (i_rx_valid) begin
          case (i_rx_data)
            8'h4C: begin state <= LD_HI; ld_addr <= '0; end
            8'h43: state <= RUN;
            8'h53: state <= STEP;
            8'h52: begin o_cpu_rst <= 1'b1; cnt <= '0; end
            default: ;
          endcase
        end
        LD_HI: if (i_rx_valid) begin
          hi_byte <= i_rx_data;
          state   <= LD_LO;
        end
        // Write strobe and the end-of-load CPU reset are registered into the LD_WR cycle.
        LD_LO: if (i_rx_valid) begin
          o_imem_we   <= 1'b1;
          o_imem_addr <= ld_addr;
          o_imem_data <= {hi_byte, i_rx_data};
          if (is_last({hi_byte, i_rx_data}, ld_addr)) begin
            o_cpu_rst <= 1'b1;
            cnt       <= '0;
          end
          state <= LD_WR;
        end
        LD_WR: begin
          if (is_last(o_imem_data, o_imem_addr)) begin
            state <= IDLE;
          end else begin
            ld_addr <= ld_addr + ADDR'(1);
            state   <= LD_HI;
          end
        end
        RUN: begin
          if (i_halt) begin
            byte_idx <= '0;
            state    <= TX;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        STEP: begin
          if (!i_halt) cnt <= sat_inc(cnt);
          byte_idx <= '0;
          state    <= TX;
        end
        // Snapshot on the first byte, after any step has landed in PC/ACC.
        TX: begin
          if (byte_idx == '0) begin
            snap      <= report_now;
            o_tx_data <= byte_of(report_now, '0);
          end else begin
            o_tx_data <= byte_of(snap, byte_idx);
          end
          o_tx_start <= 1'b1;
          state      <= TX_WAIT;
        end
        TX_WAIT: if (i_tx_done) begin
          if (byte_idx == IDX_W'(NBYTES - 1)) begin
            state <= IDLE;
          end else begin
            byte_idx <= byte_idx + IDX_W'(1);
            state    <= TX;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: a small CPU/memory model answers the DUT, and
// expected reports are derived from the loaded program list.
module tb_debug_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        cpu_en;
  logic        cpu_rst;
  logic        imem_we;
  logic [10:0] imem_addr;
  logic [15:0] imem_data;
  logic [10:0] pc;
  logic [15:0] acc;
  logic        halt;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:2047];
  logic [15:0] prog [$];
  int          en_cnt = 0, rst_cnt = 0, start_cnt = 0;
  logic        both_viol = 1'b0;
  logic [10:0] wq_addr [$];
  logic [15:0] wq_data [$];
  logic        wq_rst  [$];

  always #5 clk = ~clk;

  debug_unit dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_cpu_en(cpu_en), .o_cpu_rst(cpu_rst), .o_imem_we(imem_we),
    .o_imem_addr(imem_addr), .o_imem_data(imem_data),
    .i_pc(pc), .i_acc(acc), .i_halt(halt)
  );

  // CPU model: each enabled cycle loads the operand into ACC and advances PC.
  assign halt = (mem[pc][15:11] == 5'd0);
  always @(posedge clk) begin
    if (rst || cpu_rst) begin
      pc  <= '0;
      acc <= '0;
    end else if (cpu_en) begin
      pc  <= pc + 11'd1;
      acc <= {5'b0, mem[pc][10:0]};
    end
    if (imem_we) mem[imem_addr] <= imem_data;
  end

  always @(negedge clk) begin
    if (imem_we) begin
      wq_addr.push_back(imem_addr);
      wq_data.push_back(imem_data);
      wq_rst.push_back(cpu_rst);
    end
    if (cpu_en) en_cnt++;
    if (cpu_rst) rst_cnt++;
    if (tx_start) start_cnt++;
    if (imem_we && cpu_en) both_viol = 1'b1;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic load_prog();
    send_byte(8'h4C);
    foreach (prog[i]) begin
      send_byte(prog[i][15:8]);
      send_byte(prog[i][7:0]);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_start(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_start) begin
        b  = tx_data;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_done();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic get_report(output logic [47:0] r, output bit ok);
    logic [7:0] b;
    bit k;
    r  = '0;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_start(b, k);
      if (!k) begin
        ok = 1'b0;
        break;
      end
      r = {r[39:0], b};
      pulse_done();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_start, cpu_en, cpu_rst, imem_we} !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 0000", {tx_start, cpu_en, cpu_rst, imem_we});
    end
    checks++;
    if ({tx_data, imem_addr, imem_data} !== 35'd0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h want 0", tx_data, imem_addr, imem_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    int base, r0, n;
    base = wq_addr.size();
    r0 = rst_cnt;
    prog = '{16'h0802, 16'h1803, 16'h0000};
    load_prog();
    n = wq_addr.size() - base;
    checks++;
    if (n !== 3) begin errors++; $display("FAIL load_count got %0d want 3", n); end
    for (int i = 0; i < 3; i++) begin
      if (base + i < wq_addr.size()) begin
        checks++;
        if (wq_addr[base+i] !== 11'(i) || wq_data[base+i] !== prog[i] ||
            wq_rst[base+i] !== (i == 2)) begin
          errors++;
          $display("FAIL load_word%0d got a=%h d=%h r=%b want a=%h d=%h r=%b", i,
                   wq_addr[base+i], wq_data[base+i], wq_rst[base+i], i, prog[i], (i == 2));
        end
      end
    end
    checks++;
    if (rst_cnt - r0 !== 1) begin errors++; $display("FAIL load_cpu_rst got %0d want 1", rst_cnt - r0); end
    base = wq_addr.size();
    send_byte(8'h08);
    send_byte(8'h02);
    repeat (3) @(negedge clk);
    checks++;
    if (wq_addr.size() !== base) begin
      errors++;
      $display("FAIL load_back_idle got %0d writes want 0", wq_addr.size() - base);
    end
  endtask

  task automatic test_run();
    logic [47:0] r;
    bit ok;
    int e0;
    e0 = en_cnt;
    send_byte(8'h43);
    get_report(r, ok);
    checks++;
    if (!ok || r !== 48'h0002_0003_0002) begin
      errors++;
      $display("FAIL run_report got %h ok=%0d want 000200030002", r, ok);
    end
    checks++;
    if (en_cnt - e0 !== 2) begin errors++; $display("FAIL run_enables got %0d want 2", en_cnt - e0); end
  endtask

  task automatic test_step();
    logic [47:0] r, exp;
    bit ok;
    int e0, done_n;
    prog = '{16'h0802, 16'h1803, 16'h0000};
    load_prog();
    done_n = 0;
    for (int s = 1; s <= 3; s++) begin
      int want_en;
      want_en = (done_n < 2) ? 1 : 0;
      done_n += want_en;
      exp = {5'b0, 11'(done_n), 5'b0, prog[done_n-1][10:0], 16'(done_n)};
      e0 = en_cnt;
      send_byte(8'h53);
      get_report(r, ok);
      checks++;
      if (!ok || r !== exp) begin
        errors++;
        $display("FAIL step%0d_report got %h ok=%0d want %h", s, r, ok, exp);
      end
      checks++;
      if (en_cnt - e0 !== want_en) begin
        errors++;
        $display("FAIL step%0d_enables got %0d want %0d", s, en_cnt - e0, want_en);
      end
    end
  endtask

  task automatic test_ignored();
    logic [7:0] b;
    logic [47:0] r;
    bit ok, k;
    int s0, e0, w0, r0;
    s0 = start_cnt; e0 = en_cnt; w0 = wq_addr.size(); r0 = rst_cnt;
    send_byte(8'h41);
    repeat (5) @(negedge clk);
    checks++;
    if (start_cnt != s0 || en_cnt != e0 || wq_addr.size() != w0 || rst_cnt != r0) begin
      errors++;
      $display("FAIL ignored_byte got tx=%0d en=%0d we=%0d rst=%0d want all 0",
               start_cnt - s0, en_cnt - e0, wq_addr.size() - w0, rst_cnt - r0);
    end
    send_byte(8'h53);
    wait_start(b, k);
    r = {40'd0, b};
    send_byte(8'h4C);
    send_byte(8'h43);
    send_byte(8'h52);
    repeat (15) @(negedge clk);
    checks++;
    if (!k || start_cnt - s0 !== 1 || en_cnt != e0 || wq_addr.size() != w0 || rst_cnt != r0) begin
      errors++;
      $display("FAIL tx_hold got starts=%0d en=%0d we=%0d rst=%0d want 1,0,0,0",
               start_cnt - s0, en_cnt - e0, wq_addr.size() - w0, rst_cnt - r0);
    end
    pulse_done();
    ok = k;
    for (int i = 1; i < 6; i++) begin
      wait_start(b, k);
      if (!k) ok = 1'b0;
      r = {r[39:0], b};
      pulse_done();
    end
    checks++;
    if (!ok || r !== 48'h0002_0003_0002) begin
      errors++;
      $display("FAIL tx_hold_report got %h ok=%0d want 000200030002", r, ok);
    end
  endtask

  task automatic test_reset_midop();
    int w0, s0, e0;
    send_byte(8'h4C);
    send_byte(8'h08);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_start, cpu_en, cpu_rst, imem_we, tx_data, imem_addr, imem_data} !== 39'd0) begin
      errors++;
      $display("FAIL rst_ld_outputs got %b %h %h %h want 0",
               {tx_start, cpu_en, cpu_rst, imem_we}, tx_data, imem_addr, imem_data);
    end
    rst = 1'b0;
    w0 = wq_addr.size();
    send_byte(8'h02);
    repeat (3) @(negedge clk);
    checks++;
    if (wq_addr.size() !== w0) begin errors++; $display("FAIL rst_ld_discard got %0d writes want 0", wq_addr.size() - w0); end
    prog = '{16'h0805, 16'h0000};
    load_prog();
    checks++;
    if (wq_addr.size() != w0 + 2 || wq_addr[w0] !== 11'd0 || wq_data[w0] !== 16'h0805) begin
      errors++;
      $display("FAIL rst_ld_restart got n=%0d want first write a=000 d=0805", wq_addr.size() - w0);
    end
    prog.delete();
    for (int i = 0; i < 30; i++) prog.push_back(16'h0801);
    prog.push_back(16'h0000);
    load_prog();
    send_byte(8'h43);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_start, cpu_en, cpu_rst, imem_we} !== 4'b0) begin
      errors++;
      $display("FAIL rst_run_outputs got %b want 0000", {tx_start, cpu_en, cpu_rst, imem_we});
    end
    rst = 1'b0;
    s0 = start_cnt; e0 = en_cnt;
    repeat (40) @(negedge clk);
    checks++;
    if (start_cnt != s0 || en_cnt != e0) begin
      errors++;
      $display("FAIL rst_run_quiet got tx=%0d en=%0d want 0,0", start_cnt - s0, en_cnt - e0);
    end
  endtask

  task automatic test_random();
    logic [47:0] r, exp;
    bit ok;
    int len, steps, w0, bad;
    logic [10:0] opr [$];
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(1, 12);
      prog.delete();
      opr.delete();
      for (int i = 0; i < len; i++) begin
        opr.push_back(11'($urandom));
        prog.push_back({5'($urandom_range(1, 31)), opr[i]});
      end
      prog.push_back({5'b0, 11'($urandom)});
      w0 = wq_addr.size();
      load_prog();
      bad = 0;
      if (wq_addr.size() != w0 + len + 1) bad = 1;
      else for (int i = 0; i <= len; i++)
        if (wq_addr[w0+i] !== 11'(i) || wq_data[w0+i] !== prog[i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rand%0d_load got %0d bad writes want 0", it, bad); end
      steps = $urandom_range(0, len);
      for (int j = 1; j <= steps; j++) begin
        exp = {5'b0, 11'(j), 5'b0, opr[j-1], 16'(j)};
        send_byte(8'h53);
        get_report(r, ok);
        checks++;
        if (!ok || r !== exp) begin
          errors++;
          $display("FAIL rand%0d_step%0d got %h ok=%0d want %h", it, j, r, ok, exp);
        end
      end
      exp = {5'b0, 11'(len), 5'b0, opr[len-1], 16'(len)};
      send_byte(8'h43);
      get_report(r, ok);
      checks++;
      if (!ok || r !== exp) begin
        errors++;
        $display("FAIL rand%0d_run got %h ok=%0d want %h", it, r, ok, exp);
      end
    end
  endtask

  task automatic test_boundary();
    logic [47:0] r;
    bit ok;
    int w0, r0, n;
    prog.delete();
    for (int i = 0; i < 2048; i++) prog.push_back({5'b00001, 11'(i) ^ 11'h555});
    w0 = wq_addr.size();
    r0 = rst_cnt;
    load_prog();
    n = wq_addr.size() - w0;
    checks++;
    if (n != 2048 || wq_addr[wq_addr.size()-1] !== 11'h7FF ||
        wq_data[wq_data.size()-1] !== prog[2047] || wq_rst[wq_rst.size()-1] !== 1'b1) begin
      errors++;
      $display("FAIL bound_load got n=%0d last a=%h want n=2048 last a=7ff with cpu_rst", n,
               wq_addr[wq_addr.size()-1]);
    end
    checks++;
    if (rst_cnt - r0 !== 1) begin errors++; $display("FAIL bound_cpu_rst got %0d want 1", rst_cnt - r0); end
    send_byte(8'h53);
    get_report(r, ok);
    checks++;
    if (!ok || r !== 48'h0001_0555_0001) begin
      errors++;
      $display("FAIL bound_idle_step got %h ok=%0d want 000105550001", r, ok);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load();
    test_run();
    test_step();
    test_ignored();
    test_reset_midop();
    test_random();
    test_boundary();
    checks++;
    if (both_viol !== 1'b0) begin errors++; $display("FAIL we_and_en got 1 want 0"); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
